// File: rtl/xmem_bridge.sv
// Bridge from the b16 cpu memory port to an 8-bit asynchronous SRAM/flash.
// Each 16-bit access becomes one or two byte phases of ws+1 cycles, stalling the cpu via run.
module xmem_bridge #(
    parameter int unsigned l  = 16,
    parameter int unsigned ws = 2,
    parameter int unsigned cw = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         sel,
    input  logic [l-1:0] cpu_addr,
    input  logic         cpu_rd,
    input  logic [1:0]   cpu_wr,
    input  logic [l-1:0] cpu_dout,
    output logic [l-1:0] cpu_din,
    output logic         run,
    output logic [l-1:0] xaddr,
    output logic [7:0]   xdata_o,
    input  logic [7:0]   xdata_i,
    output logic         xdata_oe,
    output logic         xce_n,
    output logic         xoe_n,
    output logic         xwe_n
);

    typedef enum logic [1:0] {StIdle, StEven, StOdd, StDone} state_e;

    localparam logic [cw-1:0] WsLoad = cw'(ws);

    state_e        state_q, state_d;
    logic [cw-1:0] cnt_q, cnt_d;
    logic [l-1:0]  hold_q, hold_d;
    logic [l-1:0]  xaddr_q, xaddr_d;
    logic [7:0]    xdata_o_q, xdata_o_d;
    logic          xdata_oe_q, xdata_oe_d;
    logic          xce_n_q, xce_n_d;
    logic          xoe_n_q, xoe_n_d;
    logic          xwe_n_q, xwe_n_d;

    logic is_wr, is_rd, req, last, phase_d;
    logic unused_addr0;

    assign unused_addr0 = cpu_addr[0];

    // A write wins over rd; the cpu never asserts both.
    assign is_wr = |cpu_wr;
    assign is_rd = cpu_rd & ~is_wr;
    assign req   = sel & (cpu_rd | is_wr);
    assign last  = (cnt_q == '0);

    assign run = ~(req & (state_q != StDone));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = (is_rd || cpu_wr[1]) ? StEven : StOdd;
                    cnt_d   = WsLoad;
                end
            end
            StEven: begin
                if (last) begin
                    if (is_rd) begin
                        hold_d[l-1:l-8] = xdata_i;
                    end
                    // Losing sel mid-access finishes this phase and skips the odd byte.
                    if (sel && (is_rd || cpu_wr[0])) begin
                        state_d = StOdd;
                        cnt_d   = WsLoad;
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StOdd: begin
                if (last) begin
                    if (is_rd) begin
                        hold_d[7:0] = xdata_i;
                    end
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes are registered from the next state so they line up with the phase itself.
    always_comb begin
        phase_d    = (state_d == StEven) || (state_d == StOdd);
        xce_n_d    = ~phase_d;
        xoe_n_d    = ~(phase_d & is_rd);
        xwe_n_d    = ~(phase_d & is_wr & (cnt_d != '0));
        xdata_oe_d = phase_d & is_wr;
        xaddr_d    = xaddr_q;
        xdata_o_d  = xdata_o_q;
        if (phase_d) begin
            xaddr_d = {cpu_addr[l-1:1], (state_d == StOdd)};
        end
        if (state_d == StEven) begin
            xdata_o_d = cpu_dout[l-1:l-8];
        end else if (state_d == StOdd) begin
            xdata_o_d = cpu_dout[7:0];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            hold_q     <= '0;
            xaddr_q    <= '0;
            xdata_o_q  <= '0;
            xdata_oe_q <= 1'b0;
            xce_n_q    <= 1'b1;
            xoe_n_q    <= 1'b1;
            xwe_n_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            xaddr_q    <= xaddr_d;
            xdata_o_q  <= xdata_o_d;
            xdata_oe_q <= xdata_oe_d;
            xce_n_q    <= xce_n_d;
            xoe_n_q    <= xoe_n_d;
            xwe_n_q    <= xwe_n_d;
        end
    end

    assign cpu_din  = hold_q;
    assign xaddr    = xaddr_q;
    assign xdata_o  = xdata_o_q;
    assign xdata_oe = xdata_oe_q;
    assign xce_n    = xce_n_q;
    assign xoe_n    = xoe_n_q;
    assign xwe_n    = xwe_n_q;

endmodule

// File: tb/tb_xmem_bridge.sv
// Directed bench for xmem_bridge (ws=2) against a byte-wide asynchronous SRAM model.
module tb_xmem_bridge;

    logic        clk = 1'b0;
    logic        nreset;
    logic        sel;
    logic [15:0] cpu_addr;
    logic        cpu_rd;
    logic [1:0]  cpu_wr;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        run;
    logic [15:0] xaddr;
    logic [7:0]  xdata_o;
    logic [7:0]  xdata_i;
    logic        xdata_oe, xce_n, xoe_n, xwe_n;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] mem [0:65535];
    int         wr_strobes = 0;

    int          r_run_low, r_oe_low, r_we_low, r_ce_low;
    logic [15:0] r_din, r_addr_first, r_addr_last;
    logic [7:0]  r_dat_first;
    logic        r_oe_done, r_seen_dat;

    xmem_bridge #(.l(16), .ws(2), .cw(4)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .sel      (sel),
        .cpu_addr (cpu_addr),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_dout (cpu_dout),
        .cpu_din  (cpu_din),
        .run      (run),
        .xaddr    (xaddr),
        .xdata_o  (xdata_o),
        .xdata_i  (xdata_i),
        .xdata_oe (xdata_oe),
        .xce_n    (xce_n),
        .xoe_n    (xoe_n),
        .xwe_n    (xwe_n)
    );

    always #5 clk = ~clk;

    assign xdata_i = (xce_n === 1'b0 && xoe_n === 1'b0) ? mem[xaddr] : 8'hFF;

    // SRAM commits the write on the rising edge of WE while the chip is selected.
    always @(posedge xwe_n) begin
        if (xce_n === 1'b0) begin
            mem[xaddr] = xdata_o;
            wr_strobes++;
        end
    end

    // Presents one access now (caller is just past a posedge) and returns just past
    // the edge that consumes it, leaving the request lines as they are.
    task automatic access(input logic rd, input logic [1:0] wr, input logic [15:0] addr,
                          input logic [15:0] dout);
        logic done;
        done = 1'b0;
        sel = 1'b1; cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_dout = dout;
        r_run_low = 0; r_oe_low = 0; r_we_low = 0; r_ce_low = 0;
        r_addr_first = 16'hxxxx; r_addr_last = 16'hxxxx; r_dat_first = 8'hxx;
        r_seen_dat = 1'b0; r_oe_done = 1'bx; r_din = 16'hxxxx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (run) begin
                r_din     = cpu_din;
                r_oe_done = xdata_oe;
                done      = 1'b1;
                break;
            end
            r_run_low++;
            if (!xoe_n) r_oe_low++;
            if (!xwe_n) r_we_low++;
            if (!xce_n) begin
                r_ce_low++;
                if (r_ce_low == 1) r_addr_first = xaddr;
                r_addr_last = xaddr;
            end
            if (xdata_oe && !r_seen_dat) begin
                r_dat_first = xdata_o;
                r_seen_dat  = 1'b1;
            end
        end
        compared++;
        if (!done) begin
            mismatched++;
            $display("FAIL access_timeout: run still low after 40 cycles, want completion");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        cpu_rd = 1'b0; cpu_wr = 2'b00;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #12;
        compared++;
        if ({xce_n, xoe_n, xwe_n, xdata_oe} !== 4'b1110) begin
            mismatched++;
            $display("FAIL reset_strobes: got %b want 1110", {xce_n, xoe_n, xwe_n, xdata_oe});
        end
        compared++;
        if ({xaddr, xdata_o, cpu_din} !== 40'h0) begin
            mismatched++;
            $display("FAIL reset_regs: got %h/%h/%h want 0/0/0", xaddr, xdata_o, cpu_din);
        end
        compared++;
        if (run !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_run_idle: got %b want 1", run);
        end
        sel = 1'b1; cpu_rd = 1'b1; #1;
        compared++;
        if (run !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_run_req: got %b want 0", run);
        end
        sel = 1'b0; cpu_rd = 1'b0;
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_read();
        access(1'b1, 2'b00, 16'h8004, 16'h0000);
        idle_cycle();
        compared++;
        if (r_din !== 16'h1234) begin
            mismatched++;
            $display("FAIL rd_din: got %h want 1234", r_din);
        end
        compared++;
        if (r_run_low !== 7 || r_oe_low !== 6 || r_we_low !== 0) begin
            mismatched++;
            $display("FAIL rd_timing: got run %0d oe %0d we %0d want 7/6/0",
                     r_run_low, r_oe_low, r_we_low);
        end
        compared++;
        if (r_addr_first !== 16'h8004 || r_addr_last !== 16'h8005) begin
            mismatched++;
            $display("FAIL rd_xaddr: got %h..%h want 8004..8005", r_addr_first, r_addr_last);
        end
    endtask

    task automatic test_byte_write_even();
        access(1'b0, 2'b10, 16'h8006, 16'hAB00);
        idle_cycle();
        compared++;
        if (r_run_low !== 4 || r_we_low !== 2 || r_ce_low !== 3 || r_oe_low !== 0) begin
            mismatched++;
            $display("FAIL wre_timing: got run %0d we %0d ce %0d oe %0d want 4/2/3/0",
                     r_run_low, r_we_low, r_ce_low, r_oe_low);
        end
        compared++;
        if (r_addr_first !== 16'h8006 || r_addr_last !== 16'h8006 || r_dat_first !== 8'hAB) begin
            mismatched++;
            $display("FAIL wre_bus: got %h..%h data %h want 8006..8006 data ab",
                     r_addr_first, r_addr_last, r_dat_first);
        end
        compared++;
        if (mem[16'h8006] !== 8'hAB || mem[16'h8007] !== 8'h77) begin
            mismatched++;
            $display("FAIL wre_mem: got %h %h want ab 77", mem[16'h8006], mem[16'h8007]);
        end
    endtask

    task automatic test_byte_write_odd();
        access(1'b0, 2'b01, 16'h8008, 16'h00CD);
        idle_cycle();
        compared++;
        if (r_run_low !== 4 || r_addr_first !== 16'h8009 || r_dat_first !== 8'hCD) begin
            mismatched++;
            $display("FAIL wro_bus: got run %0d addr %h data %h want 4 8009 cd",
                     r_run_low, r_addr_first, r_dat_first);
        end
        compared++;
        if (mem[16'h8008] !== 8'h66 || mem[16'h8009] !== 8'hCD) begin
            mismatched++;
            $display("FAIL wro_mem: got %h %h want 66 cd", mem[16'h8008], mem[16'h8009]);
        end
    endtask

    task automatic test_word_write();
        access(1'b0, 2'b11, 16'h8010, 16'hBEEF);
        idle_cycle();
        compared++;
        if (mem[16'h8010] !== 8'hBE || mem[16'h8011] !== 8'hEF) begin
            mismatched++;
            $display("FAIL wrw_mem: got %h %h want be ef", mem[16'h8010], mem[16'h8011]);
        end
        compared++;
        if (r_run_low !== 7 || r_we_low !== 4 || r_oe_done !== 1'b0) begin
            mismatched++;
            $display("FAIL wrw_timing: got run %0d we %0d oe_done %b want 7/4/0",
                     r_run_low, r_we_low, r_oe_done);
        end
        compared++;
        if (r_din !== 16'h1234) begin
            mismatched++;
            $display("FAIL wrw_din_kept: got %h want 1234", r_din);
        end
    endtask

    task automatic test_back_to_back();
        int strobes0;
        access(1'b1, 2'b00, 16'h8020, 16'h0000);
        compared++;
        if (r_din !== 16'hA1B2 || r_run_low !== 7) begin
            mismatched++;
            $display("FAIL b2b_rd1: got %h run %0d want a1b2 7", r_din, r_run_low);
        end
        access(1'b1, 2'b00, 16'h8022, 16'h0000);
        compared++;
        if (r_din !== 16'hC3D4 || r_run_low !== 7) begin
            mismatched++;
            $display("FAIL b2b_rd2: got %h run %0d want c3d4 7", r_din, r_run_low);
        end
        strobes0 = wr_strobes;
        access(1'b0, 2'b11, 16'h8030, 16'h1357);
        access(1'b1, 2'b00, 16'h8030, 16'h0000);
        idle_cycle();
        compared++;
        if (r_din !== 16'h1357) begin
            mismatched++;
            $display("FAIL b2b_wr_rd: got %h want 1357", r_din);
        end
        compared++;
        if (wr_strobes - strobes0 !== 2) begin
            mismatched++;
            $display("FAIL b2b_strobes: got %0d want 2", wr_strobes - strobes0);
        end
    endtask

    task automatic test_sel_zero();
        int run_low, ce_low;
        run_low = 0; ce_low = 0;
        sel = 1'b0; cpu_rd = 1'b1; cpu_addr = 16'h8004;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!run) run_low++;
            if (!xce_n) ce_low++;
        end
        compared++;
        if (run_low !== 0 || ce_low !== 0) begin
            mismatched++;
            $display("FAIL sel0_idle: got run_low %0d ce_low %0d want 0 0", run_low, ce_low);
        end
        compared++;
        if (cpu_din !== 16'h1357) begin
            mismatched++;
            $display("FAIL sel0_din: got %h want 1357", cpu_din);
        end
        cpu_rd = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_write();
        sel = 1'b1; cpu_rd = 1'b0; cpu_wr = 2'b11; cpu_addr = 16'h8040; cpu_dout = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (xwe_n !== 1'b0 || xdata_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_mid_pre: got we_n %b oe %b want 0 1", xwe_n, xdata_oe);
        end
        #2 nreset = 1'b0;
        #1;
        compared++;
        if (xwe_n !== 1'b1 || xdata_oe !== 1'b0 || xce_n !== 1'b1 || cpu_din !== 16'h0) begin
            mismatched++;
            $display("FAIL rst_mid_async: got we_n %b oe %b ce_n %b din %h want 1 0 1 0",
                     xwe_n, xdata_oe, xce_n, cpu_din);
        end
        cpu_wr = 2'b00;
        @(negedge clk); nreset = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 2'b00, 16'h8004, 16'h0000);
        idle_cycle();
        compared++;
        if (r_din !== 16'h1234 || r_run_low !== 7 || r_addr_first !== 16'h8004) begin
            mismatched++;
            $display("FAIL rst_mid_after: got %h run %0d addr %h want 1234 7 8004",
                     r_din, r_run_low, r_addr_first);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h5A;
        mem[16'h8004] = 8'h12; mem[16'h8005] = 8'h34;
        mem[16'h8007] = 8'h77; mem[16'h8008] = 8'h66;
        mem[16'h8020] = 8'hA1; mem[16'h8021] = 8'hB2;
        mem[16'h8022] = 8'hC3; mem[16'h8023] = 8'hD4;
        nreset = 1'b0; sel = 1'b0; cpu_rd = 1'b0; cpu_wr = 2'b00;
        cpu_addr = 16'h0000; cpu_dout = 16'h0000;
        test_reset();
        test_word_read();
        test_byte_write_even();
        test_byte_write_odd();
        test_word_write();
        test_back_to_back();
        test_sel_zero();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
